// File: rtl/gate_unit.sv
// Two-stage bitwise logic unit: S1 captures operands, S2 presents the result
// with zero/parity flags. An optional accumulator can stand in for operand b.
module gate_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic [CNT_W-1:0] done_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOTA = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  // Handshake: a beat moves on a port only at a rising edge where valid and
  // ready are both 1. valid never waits on ready; in_ready never looks at in_valid.

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic             s1_acc_en_q, s1_acc_en_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             in_fire;
  logic             out_fire;
  logic             s1_adv;
  logic [WIDTH-1:0] opnd_b;
  logic [WIDTH-1:0] alu_res;

  assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;

  always_comb begin
    in_fire  = in_valid && in_ready;
    out_fire = s2_valid_q && out_ready;
    s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
    opnd_b   = s1_acc_en_q ? acc_q : s1_b_q;
  end

  always_comb begin
    alu_res = s1_a_q;
    case (s1_op_q)
      OP_AND:  alu_res = s1_a_q & opnd_b;
      OP_OR:   alu_res = s1_a_q | opnd_b;
      OP_NOTA: alu_res = ~s1_a_q;
      OP_NAND: alu_res = ~(s1_a_q & opnd_b);
      OP_NOR:  alu_res = ~(s1_a_q | opnd_b);
      OP_XOR:  alu_res = s1_a_q ^ opnd_b;
      OP_XNOR: alu_res = ~(s1_a_q ^ opnd_b);
      OP_PASS: alu_res = s1_a_q;
      default: alu_res = s1_a_q;
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_op_d     = s1_op_q;
    s1_acc_en_d = s1_acc_en_q;
    if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    if (in_fire) begin
      s1_valid_d  = 1'b1;
      s1_a_d      = a;
      s1_b_d      = b;
      s1_op_d     = op;
      s1_acc_en_d = acc_en;
    end
  end

  // S2 keeps its last result after draining so the outputs only change on a load.
  always_comb begin
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    zero_d     = zero_q;
    parity_d   = parity_q;
    if (out_fire) begin
      s2_valid_d = 1'b0;
    end
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      result_d   = alu_res;
      zero_d     = (alu_res == '0);
      parity_d   = ^alu_res;
    end
  end

  // Clear beats a same-edge accumulator load.
  always_comb begin
    acc_d = acc_q;
    if (s1_adv && s1_acc_en_q) begin
      acc_d = alu_res;
    end
    if (acc_clr) begin
      acc_d = '0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_fire && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= 3'd0;
      s1_acc_en_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      parity_q    <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      s1_acc_en_q <= s1_acc_en_d;
      s2_valid_q  <= s2_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      parity_q    <= parity_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign parity    = parity_q;
  assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_gate_unit.sv
// Directed bench for gate_unit: hand-computed vectors plus an in-order
// scoreboard of accepted transactions; a CNT_W=2 twin checks saturation.
module tb_gate_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  a, b;
  logic [2:0]  op;
  logic        acc_en, acc_clr, out_ready;
  logic        in_ready, out_valid, zero, parity;
  logic [7:0]  result;
  logic [15:0] done_cnt;
  logic        s_in_ready, s_out_valid, s_zero, s_parity;
  logic [7:0]  s_result;
  logic [1:0]  s_done_cnt;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  cur_exp;
  logic [7:0]  exp_q[$];

  gate_unit #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .parity(parity), .done_cnt(done_cnt)
  );

  gate_unit #(.WIDTH(8), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .op(op), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(s_out_valid), .out_ready(out_ready), .result(s_result),
    .zero(s_zero), .parity(s_parity), .done_cnt(s_done_cnt)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $error("FAIL watchdog observed=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] e);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_result"}, result, e);
    chk({tag, "_zero"}, zero, (e == 8'h00));
    chk({tag, "_parity"}, parity, ^e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] av,
                       input logic [7:0] bv, input logic ae, input logic ac,
                       input logic ordy, input logic [7:0] e);
    in_valid  = v;
    op        = o;
    a         = av;
    b         = bv;
    acc_en    = ae;
    acc_clr   = ac;
    out_ready = ordy;
    cur_exp   = e;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, ordy, 8'h00);
  endtask

  // scoreboard: inputs are stable from posedge+1 to the next posedge
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_output", {56'd0, result}, 64'hdead);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("sb_result", result, e);
        chk("sb_zero", zero, (e == 8'h00));
        chk("sb_parity", parity, ^e);
      end
    end
    if (rst_n && in_valid && in_ready) begin
      exp_q.push_back(cur_exp);
    end
  end

  logic [7:0] exp31 [8] = '{8'h30, 8'hFC, 8'h0F, 8'hCF, 8'h03, 8'hCC, 8'h33, 8'hF0};
  logic [7:0] acc_a [4] = '{8'h01, 8'h02, 8'h04, 8'hFF};
  logic [2:0] acc_op[4] = '{3'd1, 3'd1, 3'd1, 3'd5};
  logic [7:0] acc_e [4] = '{8'h01, 8'h03, 8'h07, 8'hF8};

  initial begin
    rst_n = 1'b0;
    idle(1'b0);

    // reset state
    tick(); #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 8'h00);
    chk("rst_zero", zero, 1'b1);
    chk("rst_parity", parity, 1'b0);
    chk("rst_done_cnt", done_cnt, 16'd0);
    tick(); rst_n = 1'b1; idle(1'b1); #1;
    chk("post_rst_in_ready", in_ready, 1'b1);

    // all eight ops back to back, results two cycles after input
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i < 8) drive(1'b1, 3'(i), 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b1, exp31[i]);
      else       idle(1'b1);
      #1;
      chk("ops_in_ready", in_ready, 1'b1);
      if (i < 2) chk("ops_lat_valid", out_valid, 1'b0);
      else       chk_out("ops", exp31[i-2]);
      if (i == 4) begin
        chk("ops_cnt2", done_cnt, 16'd2);
        chk("sat_cnt2", s_done_cnt, 2'd2);
      end
    end
    tick(); idle(1'b1); #1;
    chk("ops_done_cnt8", done_cnt, 16'd8);
    chk("sat_done_cnt3", s_done_cnt, 2'd3);
    chk("ops_drained", out_valid, 1'b0);

    // accumulator chain
    tick(); drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00); #1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k < 4) drive(1'b1, acc_op[k], acc_a[k], 8'hAA, 1'b1, 1'b0, 1'b1, acc_e[k]);
      else       idle(1'b1);
      #1;
      if (k >= 2) chk_out("acc_chain", acc_e[k-2]);
    end

    // clear wins over a same-edge accumulator load; pipeline keeps its entry
    tick(); drive(1'b1, 3'd1, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 8'hF9); #1;
    tick(); drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00); #1;
    tick(); drive(1'b1, 3'd1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00); #1;
    chk_out("clr_keep", 8'hF9);
    tick(); idle(1'b1); #1;
    tick(); idle(1'b1); #1;
    chk_out("clr_wins", 8'h00);

    // flags
    tick(); drive(1'b1, 3'd0, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b1, 8'h00); #1;
    tick(); drive(1'b1, 3'd7, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01); #1;
    tick(); idle(1'b1); #1;
    chk_out("flag_and", 8'h00);
    tick(); idle(1'b1); #1;
    chk_out("flag_pass", 8'h01);
    tick(); idle(1'b0); #1;

    // backpressure
    tick(); drive(1'b1, 3'd5, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 8'h26); #1;
    chk("bp_rdy0", in_ready, 1'b1);
    tick(); drive(1'b1, 3'd0, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0, 8'h0F); #1;
    chk("bp_rdy1", in_ready, 1'b1);
    tick(); drive(1'b1, 3'd4, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 8'hFE); #1;
    chk("bp_rdy2_full", in_ready, 1'b0);
    chk_out("bp_stall_a", 8'h26);
    tick(); #1;
    chk("bp_rdy3_full", in_ready, 1'b0);
    chk_out("bp_stall_b", 8'h26);
    tick(); out_ready = 1'b1; #1;
    chk("bp_rdy4_release", in_ready, 1'b1);
    chk_out("bp_first", 8'h26);
    tick(); idle(1'b1); #1;
    chk_out("bp_second", 8'h0F);
    tick(); idle(1'b1); #1;
    chk_out("bp_third", 8'hFE);
    tick(); idle(1'b1); #1;
    chk("bp_drained", out_valid, 1'b0);
    chk("bp_queue_empty", exp_q.size(), 0);

    // reset with both stages full, overriding a concurrent transfer and clear
    tick(); drive(1'b1, 3'd7, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5A); #1;
    tick(); drive(1'b1, 3'd1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5A); #1;
    tick(); rst_n = 1'b0; drive(1'b1, 3'd0, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF); #1;
    tick(); rst_n = 1'b1; idle(1'b1); #1;
    chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_done_cnt", done_cnt, 16'd0);
    chk("mrst_sat_cnt", s_done_cnt, 2'd0);
    chk("mrst_in_ready", in_ready, 1'b1);
    chk("mrst_result", result, 8'h00);
    chk("mrst_zero", zero, 1'b1);
    exp_q.delete();
    tick(); drive(1'b1, 3'd1, 8'h00, 8'h77, 1'b1, 1'b0, 1'b1, 8'h00); #1;
    tick(); idle(1'b1); #1;
    tick(); idle(1'b1); #1;
    chk_out("mrst_acc_zero", 8'h00);
    tick(); idle(1'b1); #1;
    chk("mrst_cnt1", done_cnt, 16'd1);
    chk("end_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gate_unit.md
GATE_UNIT -- requirements
Module: gate_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand/result width (legal 1..64).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the completed-transaction counter width.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1: an operand set is offered.
REQ-006 The block SHALL have port in_ready, output, 1: the block accepts the operand set this cycle.
REQ-007 The block SHALL have ports a and b, input, WIDTH each: operands.
REQ-008 The block SHALL have port op, input, 3: operation select (REQ-015).
REQ-009 The block SHALL have port acc_en, input, 1: substitute the accumulator for b.
REQ-010 The block SHALL have port acc_clr, input, 1: accumulator clear pulse.
REQ-011 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1): output handshake.
REQ-012 The block SHALL have ports result (output, WIDTH), zero (output, 1: result all zeros) and parity (output, 1: XOR-reduction of result).
REQ-013 The block SHALL have port done_cnt, output, CNT_W: count of completed output transfers.

Function
REQ-014 Transfers: input on in_valid & in_ready; output on out_valid & out_ready; both sampled at the rising edge.
REQ-015 Op encoding, bitwise over WIDTH: 0 AND, 1 OR, 2 NOT a, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 PASS a.
REQ-016 Pipeline: S1 registers a, b, op, acc_en on input transfer; S2 registers result, zero, parity.
REQ-017 result is computed from S1 contents when S1 advances into S2; latency from input transfer to out_valid is exactly 2 cycles with no stall.
REQ-018 S2 loads when S1 valid and (S2 empty or S2 output transfer this cycle); otherwise S1 holds.
REQ-019 in_ready = !S1_valid | S2_empty | out_ready, combinational, with no dependence on in_valid.
REQ-020 With out_ready held high, throughput is one transaction per cycle with no bubbles.
REQ-021 While out_valid is high and out_ready is low, result, zero and parity are held stable.
REQ-022 S1 and S2 each hold exactly one entry; no more than 2 transactions are in flight.
REQ-023 When S1 acc_en = 1, the b operand is the accumulator value at the S1-to-S2 edge, and the accumulator loads the computed result at that same edge.
REQ-024 Back-to-back acc_en transactions chain: each uses the previous transaction's result with no hazard.
REQ-025 acc_clr = 1 sets the accumulator to 0 at the next edge and wins over a simultaneous REQ-023 update; pipeline contents are unaffected.
REQ-026 done_cnt increments by 1 per output transfer and saturates at 2^CNT_W-1 without wrapping.
REQ-027 zero and parity describe the currently presented result only.

Reset
REQ-028 While rst_n = 0 at an edge: S1_valid = 0, S2_valid = 0, out_valid = 0, result = 0, zero = 1, parity = 0, accumulator = 0, done_cnt = 0.
REQ-029 in_ready SHALL be 1 during and immediately after reset.
REQ-030 Reset mid-operation discards all in-flight transactions and the accumulator with no output transfer, overriding any concurrent transfer, acc_clr or counter update.

Verification
REQ-031 WIDTH=8, out_ready=1, a=0xF0, b=0x3C, ops 0..7 on consecutive cycles -> results 0x30,0xFC,0x0F,0xCF,0x03,0xCC,0x33,0xF0, each 2 cycles after its input; done_cnt=8.
REQ-032 Accumulator chain: acc_clr; then op=1 acc_en=1 with a=0x01, 0x02, 0x04 -> results 0x01, 0x03, 0x07; then op=5 acc_en=1 with a=0xFF -> result 0xF8, parity=1.
REQ-033 Backpressure: out_ready=0, three inputs offered -> two accepted, in_ready=0 on the third; raise out_ready -> results delivered in order, none lost or duplicated, outputs stable while stalled.
REQ-034 Flags: op=0 with a=0xAA, b=0x55 -> result 0x00, zero=1, parity=0; op=7 with a=0x01 -> zero=0, parity=1.
REQ-035 Saturation and reset: CNT_W=2, five transfers -> done_cnt stops at 3; rst_n=0 with both stages full -> next cycle out_valid=0, done_cnt=0, in_ready=1, accumulator 0.
